// File: rtl/barrel_shifter.sv
// Lane-granular left rotator: PORT lanes of WIDTH bits, rotated by 'select' lanes
// through SEL_WIDTH cascaded power-of-two stages, with a single output register.
module barrel_shifter #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned PORT        = 8,
    parameter int unsigned SEL_WIDTH   = 3,
    parameter int unsigned TOTAL_WIDTH = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEL_WIDTH-1:0]   select,
    input  logic [TOTAL_WIDTH-1:0] data_in,
    input  logic                   valid_in,
    output logic [TOTAL_WIDTH-1:0] data_out,
    output logic                   valid_out
);

    // Lane count widened by one bit so 'select >= PORT' compares without truncation.
    localparam logic [SEL_WIDTH:0] PortCount = (SEL_WIDTH + 1)'(PORT);

    logic [TOTAL_WIDTH-1:0] rot_data;
    logic [TOTAL_WIDTH-1:0] data_d;
    logic [TOTAL_WIDTH-1:0] data_q;
    logic                   valid_q;
    logic                   out_of_range;

    // Cascaded stages: stage j rotates left by (2^j mod PORT) lanes when select[j] is set.
    always_comb begin : rotate_stages
        logic [TOTAL_WIDTH-1:0] cur;
        logic [TOTAL_WIDTH-1:0] nxt;
        cur = data_in;
        nxt = data_in;
        for (int j = 0; j < int'(SEL_WIDTH); j++) begin
            for (int k = 0; k < int'(PORT); k++) begin
                if (select[j]) begin
                    nxt[k*WIDTH +: WIDTH] =
                        cur[((k + PORT - ((1 << j) % PORT)) % PORT) * WIDTH +: WIDTH];
                end else begin
                    nxt[k*WIDTH +: WIDTH] = cur[k*WIDTH +: WIDTH];
                end
            end
            cur = nxt;
        end
        rot_data = cur;
    end

    // Rotation amounts past the last lane only exist for non-power-of-two PORT; they yield zero.
    always_comb begin
        out_of_range = ({1'b0, select} >= PortCount);
        data_d       = out_of_range ? '0 : rot_data;
    end

    // Output register: capture on valid_in, otherwise hold data; valid tracks valid_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_in;
            if (valid_in) begin
                data_q <= data_d;
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench: an 8x64 instance and a 5x8 instance driven in lock-step,
// compared each cycle against a rotate-by-arithmetic reference model.
module tb_barrel_shifter;

    logic clk = 1'b0;
    logic rst;

    logic [2:0]   sel_a;
    logic [511:0] din_a;
    logic         vin_a;
    logic [511:0] dout_a;
    logic         vout_a;

    logic [2:0]   sel_b;
    logic [39:0]  din_b;
    logic         vin_b;
    logic [39:0]  dout_b;
    logic         vout_b;

    logic [511:0] exp_a;
    logic         exp_va;
    logic [511:0] exp_b;
    logic         exp_vb;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    barrel_shifter #(
        .WIDTH       (64),
        .PORT        (8),
        .SEL_WIDTH   (3),
        .TOTAL_WIDTH (512)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .select    (sel_a),
        .data_in   (din_a),
        .valid_in  (vin_a),
        .data_out  (dout_a),
        .valid_out (vout_a)
    );

    barrel_shifter #(
        .WIDTH       (8),
        .PORT        (5),
        .SEL_WIDTH   (3),
        .TOTAL_WIDTH (40)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .select    (sel_b),
        .data_in   (din_b),
        .valid_in  (vin_b),
        .data_out  (dout_b),
        .valid_out (vout_b)
    );

    // Reference: rotate the w*p-bit word left by sel*w bits; out-of-range select gives zero.
    function automatic logic [511:0] ref_rot(input logic [511:0] d, input int sel,
                                             input int w, input int p);
        logic [511:0] mask;
        int total;
        int amt;
        total = w * p;
        mask  = (512'd1 << total) - 512'd1;
        if (sel >= p) return '0;
        amt = sel * w;
        if (amt == 0) return d & mask;
        return ((d << amt) | ((d & mask) >> (total - amt))) & mask;
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: update the model from the inputs sampled at this edge, then compare.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            exp_a  = '0;
            exp_va = 1'b0;
            exp_b  = '0;
            exp_vb = 1'b0;
        end else begin
            exp_va = vin_a;
            if (vin_a) exp_a = ref_rot(din_a, int'(sel_a), 64, 8);
            exp_vb = vin_b;
            if (vin_b) exp_b = ref_rot({472'd0, din_b}, int'(sel_b), 8, 5);
        end
        #1;
        check("a_data", dout_a, exp_a);
        check("a_valid", {511'd0, vout_a}, {511'd0, exp_va});
        check("b_data", {472'd0, dout_b}, exp_b);
        check("b_valid", {511'd0, vout_b}, {511'd0, exp_vb});
    endtask

    task automatic load_index_lanes();
        for (int k = 0; k < 8; k++) din_a[k*64 +: 64] = 64'(k);
        for (int k = 0; k < 5; k++) din_b[k*8 +: 8] = 8'(k + 1);
    endtask

    initial begin
        rst   = 1'b1;
        sel_a = '0;
        din_a = '0;
        vin_a = 1'b0;
        sel_b = '0;
        din_b = '0;
        vin_b = 1'b0;
        exp_a = '0;
        exp_va = 1'b0;
        exp_b = '0;
        exp_vb = 1'b0;

        // Reset visible before any clock edge.
        #1;
        check("rst_a_data", dout_a, 512'd0);
        check("rst_a_valid", {511'd0, vout_a}, 512'd0);
        check("rst_b_data", {472'd0, dout_b}, 512'd0);
        step();
        rst = 1'b0;

        // Index-valued lanes, select swept 0..7 on consecutive cycles.
        load_index_lanes();
        vin_a = 1'b1;
        vin_b = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel_a = 3'(s);
            sel_b = 3'(s);
            step();
            if (s == 0) check("a_sel0_pass", dout_a, din_a);
            if (s == 3) begin
                check("a_sel3_lane0", {448'd0, dout_a[0 +: 64]}, 512'd5);
                check("a_sel3_lane3", {448'd0, dout_a[192 +: 64]}, 512'd0);
                check("a_sel3_lane7", {448'd0, dout_a[448 +: 64]}, 512'd4);
            end
            if (s == 4) begin
                // lanes hold 1..5; out lane k = in lane (k-4) mod 5
                check("b_sel4", {472'd0, dout_b}, {472'd0, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1} << 0
                      == '0 ? '0 : {472'd0, 8'd1, 8'd5, 8'd4, 8'd3, 8'd2});
            end
            if (s == 5 || s == 7) begin
                check("b_oor_data", {472'd0, dout_b}, 512'd0);
                check("b_oor_valid", {511'd0, vout_b}, 512'd1);
            end
        end

        // Single nonzero lane rotated by 7 lands in lane 7.
        din_a = 512'd13;
        sel_a = 3'd7;
        step();
        check("a_lane0_to_lane7", dout_a, 512'd13 << 448);

        // valid 1,0,1: data holds through the idle cycle.
        din_a = {16{32'hA5A5_0F0F}};
        sel_a = 3'd2;
        din_b = 40'h12_3456_789A;
        sel_b = 3'd1;
        step();
        vin_a = 1'b0;
        vin_b = 1'b0;
        din_a = {16{32'h1234_5678}};
        sel_a = 3'd5;
        step();
        check("a_hold", dout_a, ref_rot({16{32'hA5A5_0F0F}}, 2, 64, 8));
        vin_a = 1'b1;
        vin_b = 1'b1;
        step();

        // Reset mid-stream discards the in-flight result, asynchronously.
        din_a = {16{32'hDEAD_BEEF}};
        sel_a = 3'd1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_a_data", dout_a, 512'd0);
        check("mid_rst_a_valid", {511'd0, vout_a}, 512'd0);
        check("mid_rst_b_data", {472'd0, dout_b}, 512'd0);
        step();
        rst = 1'b0;
        sel_a = 3'd6;
        step();

        // Randomized traffic with random valid.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 16; i++) din_a[i*32 +: 32] = $urandom();
            din_b = {$urandom(), 8'($urandom())};
            sel_a = 3'($urandom_range(0, 7));
            sel_b = 3'($urandom_range(0, 7));
            vin_a = ($urandom_range(0, 3) != 0);
            vin_b = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/barrel_shifter.md
BARREL_SHIFTER -- requirements
Module: barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 64: bit width of one lane (port); SHALL be >= 1.
REQ-002 Parameter PORT, default 8: number of lanes; SHALL be >= 2.
REQ-003 Parameter SEL_WIDTH, default 3 (= $clog2(PORT)): width of select; the instantiator SHALL set it to $clog2(PORT).
REQ-004 Parameter TOTAL_WIDTH, default 512 (= WIDTH*PORT): width of the data buses; the instantiator SHALL set it to WIDTH*PORT.
REQ-005 Parameter order SHALL be WIDTH, PORT, SEL_WIDTH, TOTAL_WIDTH so positional override works.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 select  input  SEL_WIDTH  rotation amount, in lanes.
REQ-009 data_in  input  TOTAL_WIDTH  PORT lanes packed; lane k = bits [k*WIDTH +: WIDTH].
REQ-010 valid_in  input  1  qualifies select/data_in this cycle.
REQ-011 data_out  output  TOTAL_WIDTH  rotated lanes, registered.
REQ-012 valid_out  output  1  data_out holds a result captured from a valid_in cycle.

Function
REQ-013 Operation SHALL be a left rotation by whole lanes: out lane k = in lane ((k - select) mod PORT), i.e. rotate left by select*WIDTH bits.
REQ-014 select = 0 SHALL pass data_in unchanged.
REQ-015 select >= PORT (possible only when PORT is not a power of two) SHALL produce data_out = 0 with valid_out still asserted.
REQ-016 Rotation SHALL be built as SEL_WIDTH cascaded stages; stage j rotates by 2^j lanes when select[j] = 1; the datapath is combinational between the input and the output register.
REQ-017 Latency SHALL be exactly 1 cycle: select/data_in sampled at edge N with valid_in = 1 appear on data_out after edge N.
REQ-018 valid_out SHALL equal valid_in registered one cycle.
REQ-019 When valid_in = 0 at an edge, data_out SHALL hold its previous value; valid_out goes 0.
REQ-020 Throughput SHALL be one result per cycle; no backpressure, no stall.
REQ-021 No bit SHALL be lost or duplicated: data_out is a lane permutation of data_in (except REQ-015).
REQ-022 Unknown/X on select while valid_in = 1 is not a supported input; no X-masking logic is required.

Reset
REQ-023 While rst = 1, data_out SHALL be all zeros and valid_out 0, immediately, independent of clk.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight result; the first valid_in after rst deasserts yields its result one cycle later.
REQ-025 Deassertion SHALL take effect at the first rising clk edge with rst = 0.

Verification (WIDTH=64, PORT=8 unless stated)
REQ-026 Assert rst without clk edges -> data_out = 0, valid_out = 0 immediately.
REQ-027 data_in = lane k holds value k (lane0=0 .. lane7=7), select = 0, valid_in = 1 -> next cycle data_out lanes = 0..7, valid_out = 1.
REQ-028 Same data_in, sweep select 1..7 each cycle -> for select = 3, out lane0 = 5, lane3 = 0, lane7 = 4; each result 1 cycle after its input.
REQ-029 data_in = 13 (lane0 = 13, others 0), select = 7 -> out lane7 = 13, all other lanes 0.
REQ-030 valid_in 1,0,1 with different data -> valid_out 1,0,1 delayed one cycle; data_out holds during the 0 cycle.
REQ-031 WIDTH=8, PORT=5, select = 5 and 7 -> data_out = 0, valid_out = 1; select = 4 -> out lane k = in lane ((k-4) mod 5).
